// File: rtl/glitc_dp_align_pkg.sv
// Register map, field positions and small helpers shared by the datapath aligner.
// Definitions only; no state, no latency, no flow control.
package glitc_dp_align_pkg;

  localparam logic [3:0] ADDR_DPREG0     = 4'h0;
  localparam logic [3:0] ADDR_DPREG1     = 4'h1;
  localparam logic [3:0] ADDR_DPTRAINING = 4'h2;
  localparam logic [3:0] ADDR_DPREG3     = 4'h3;
  localparam logic [3:0] ADDR_DPIDELAY   = 4'h4;

  localparam int TRN_DISABLE_BIT = 31;
  localparam int TRN_BITSLIP_BIT = 30;
  localparam int TRN_SEL_HI      = 22;
  localparam int TRN_SEL_LO      = 16;
  localparam int TRN_DAT_HI      = 7;
  localparam int TRN_DAT_LO      = 0;

  localparam int DLY_LOAD_BIT = 31;
  localparam int DLY_SEL_HI   = 22;
  localparam int DLY_SEL_LO   = 16;
  localparam int DLY_TAP_HI   = 4;
  localparam int DLY_TAP_LO   = 0;

  localparam int NUM_CH  = 6;
  localparam int NUM_BIT = 12;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SELECT,
    ST_LOAD,
    ST_WAIT,
    ST_SAMPLE,
    ST_CENTER,
    ST_CHECK,
    ST_SLIP,
    ST_REPORT,
    ST_FINISH
  } state_t;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // True when the word is the pattern under any of its eight rotations.
  function automatic logic is_rotation(input logic [7:0] v, input logic [7:0] pat);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (v == rotl8(pat, 3'(i))) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [31:0] training_word(input logic dis, input logic slip,
                                                input logic [6:0] sel);
    logic [31:0] w;
    w = '0;
    w[TRN_DISABLE_BIT]           = dis;
    w[TRN_BITSLIP_BIT]           = slip;
    w[TRN_SEL_HI:TRN_SEL_LO]     = sel;
    return w;
  endfunction

  function automatic logic [31:0] idelay_word(input logic [6:0] sel, input logic [4:0] tap);
    logic [31:0] w;
    w = '0;
    w[DLY_LOAD_BIT]              = 1'b1;
    w[DLY_SEL_HI:DLY_SEL_LO]     = sel;
    w[DLY_TAP_HI:DLY_TAP_LO]     = tap;
    return w;
  endfunction

endpackage

// File: rtl/glitc_eye_tracker.sv
// Longest-run tracker over a tap sweep; best_* update on the edge that consumes a sample.
// Always accepts; no backpressure. Ties keep the earlier window.
module glitc_eye_tracker (
  input  logic       user_clk_i,
  input  logic       rst_n_i,
  input  logic       clear,
  input  logic       pass_vld,
  input  logic       pass,
  input  logic [4:0] tap,
  output logic [5:0] best_start,
  output logic [5:0] best_len
);

  logic [5:0] cur_start;
  logic [5:0] cur_len;
  logic [5:0] nxt_start;
  logic [5:0] nxt_len;

  always_comb begin
    nxt_len   = cur_len + 6'd1;
    nxt_start = (cur_len == 6'd0) ? {1'b0, tap} : cur_start;
  end

  always_ff @(posedge user_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (pass_vld) begin
      if (pass) begin
        cur_len   <= nxt_len;
        cur_start <= nxt_start;
        if (nxt_len > best_len) begin
          best_len   <= nxt_len;
          best_start <= nxt_start;
        end
      end else begin
        cur_len <= '0;
      end
    end
  end

endmodule

// File: rtl/glitc_dp_align_master.sv
// Per-bit IDELAY eye sweep, centring and bitslip alignment over the datapath register bus.
// One bus cycle per two clocks at most; abort finishes the current cycle then disables training.
module glitc_dp_align_master
  import glitc_dp_align_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = 8'hA6,
  parameter int         SETTLE_CYCLES = 64,
  parameter int         MIN_EYE       = 4,
  parameter int         MAX_SLIP      = 8
) (
  input  logic        user_clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic        user_sel_o,
  output logic        user_wr_o,
  output logic [3:0]  user_addr_o,
  output logic [31:0] user_dat_o,
  input  logic [31:0] user_dat_i,
  output logic        res_valid_o,
  output logic [6:0]  res_sel_o,
  output logic [4:0]  res_delay_o,
  output logic [5:0]  res_width_o,
  output logic [3:0]  res_slip_o,
  output logic        res_ok_o
);

  localparam logic [6:0]  LAST_SEL   = {3'(NUM_CH - 1), 4'(NUM_BIT - 1)};
  localparam logic [15:0] SETTLE_END = 16'(SETTLE_CYCLES - 1);

  state_t      state;
  state_t      wait_ret;
  logic [6:0]  sel;
  logic [6:0]  sel_next;
  logic [4:0]  tap;
  logic [3:0]  slips;
  logic [15:0] cnt;
  logic        bit_ok;

  logic [7:0]  rd_byte;
  logic        pass;
  logic        trk_clear;
  logic        trk_pass_vld;
  logic [5:0]  best_start;
  logic [5:0]  best_len;
  logic [5:0]  center;
  logic        unused_ok;

  assign rd_byte      = user_dat_i[TRN_DAT_HI:TRN_DAT_LO];
  assign unused_ok    = &{1'b0, user_dat_i[31:TRN_DAT_HI+1]};
  assign pass         = is_rotation(rd_byte, TRAIN_PATTERN);
  // A bus cycle is in flight exactly while user_sel_o is high, so these fire on its final edge.
  assign trk_clear    = (state == ST_SELECT) && user_sel_o;
  assign trk_pass_vld = (state == ST_SAMPLE) && user_sel_o;
  assign center       = best_start + {1'b0, best_len[5:1]};

  always_comb begin
    sel_next = sel + 7'd1;
    if (sel[3:0] == 4'(NUM_BIT - 1)) sel_next = {sel[6:4] + 3'd1, 4'd0};
  end

  glitc_eye_tracker u_eye (
    .user_clk_i (user_clk_i),
    .rst_n_i    (rst_n_i),
    .clear      (trk_clear),
    .pass_vld   (trk_pass_vld),
    .pass       (pass),
    .tap        (tap),
    .best_start (best_start),
    .best_len   (best_len)
  );

  always_ff @(posedge user_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      wait_ret    <= ST_IDLE;
      sel         <= '0;
      tap         <= '0;
      slips       <= '0;
      cnt         <= '0;
      bit_ok      <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      fail_o      <= 1'b0;
      user_sel_o  <= 1'b0;
      user_wr_o   <= 1'b0;
      user_addr_o <= '0;
      user_dat_o  <= '0;
      res_valid_o <= 1'b0;
      res_sel_o   <= '0;
      res_delay_o <= '0;
      res_width_o <= '0;
      res_slip_o  <= '0;
      res_ok_o    <= 1'b0;
    end else begin
      done_o      <= 1'b0;
      res_valid_o <= 1'b0;
      user_sel_o  <= 1'b0;
      user_wr_o   <= 1'b0;

      if (abort_i && busy_o && (state != ST_FINISH)) begin
        fail_o <= 1'b1;
        state  <= ST_FINISH;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              fail_o <= 1'b0;
              busy_o <= 1'b1;
              sel    <= '0;
              state  <= ST_SELECT;
            end
          end

          ST_SELECT: begin
            if (!user_sel_o) begin
              user_sel_o  <= 1'b1;
              user_wr_o   <= 1'b1;
              user_addr_o <= ADDR_DPTRAINING;
              user_dat_o  <= training_word(1'b0, 1'b0, sel);
            end else begin
              tap      <= '0;
              slips    <= '0;
              wait_ret <= ST_SAMPLE;
              state    <= ST_LOAD;
            end
          end

          ST_LOAD: begin
            if (!user_sel_o) begin
              user_sel_o  <= 1'b1;
              user_wr_o   <= 1'b1;
              user_addr_o <= ADDR_DPIDELAY;
              user_dat_o  <= idelay_word(sel, tap);
            end else begin
              cnt   <= '0;
              state <= ST_WAIT;
            end
          end

          ST_WAIT: begin
            if (cnt == SETTLE_END) state <= wait_ret;
            else                   cnt   <= cnt + 16'd1;
          end

          ST_SAMPLE: begin
            if (!user_sel_o) begin
              user_sel_o  <= 1'b1;
              user_addr_o <= ADDR_DPTRAINING;
            end else if (tap == 5'd31) begin
              state <= ST_CENTER;
            end else begin
              tap   <= tap + 5'd1;
              state <= ST_LOAD;
            end
          end

          ST_CENTER: begin
            if (best_len < 6'(MIN_EYE)) begin
              bit_ok <= 1'b0;
              state  <= ST_REPORT;
            end else begin
              tap      <= center[4:0];
              wait_ret <= ST_CHECK;
              state    <= ST_LOAD;
            end
          end

          ST_CHECK: begin
            if (!user_sel_o) begin
              user_sel_o  <= 1'b1;
              user_addr_o <= ADDR_DPTRAINING;
            end else if (rd_byte == TRAIN_PATTERN) begin
              bit_ok <= 1'b1;
              state  <= ST_REPORT;
            end else if (slips == 4'(MAX_SLIP)) begin
              bit_ok <= 1'b0;
              state  <= ST_REPORT;
            end else begin
              state <= ST_SLIP;
            end
          end

          ST_SLIP: begin
            if (!user_sel_o) begin
              user_sel_o  <= 1'b1;
              user_wr_o   <= 1'b1;
              user_addr_o <= ADDR_DPTRAINING;
              user_dat_o  <= training_word(1'b0, 1'b1, sel);
            end else begin
              slips    <= slips + 4'd1;
              cnt      <= '0;
              wait_ret <= ST_CHECK;
              state    <= ST_WAIT;
            end
          end

          ST_REPORT: begin
            res_valid_o <= 1'b1;
            res_sel_o   <= sel;
            res_delay_o <= tap;
            res_width_o <= best_len;
            res_slip_o  <= slips;
            res_ok_o    <= bit_ok;
            fail_o      <= fail_o | !bit_ok;
            if (sel == LAST_SEL) begin
              state <= ST_FINISH;
            end else begin
              sel   <= sel_next;
              state <= ST_SELECT;
            end
          end

          ST_FINISH: begin
            if (!user_sel_o) begin
              user_sel_o  <= 1'b1;
              user_wr_o   <= 1'b1;
              user_addr_o <= ADDR_DPTRAINING;
              user_dat_o  <= training_word(1'b1, 1'b0, 7'd0);
            end else begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= ST_IDLE;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glitc_dp_align_master.sv
// Directed bench: a register-file responder models per-bit eyes and bitslip rotation.
`timescale 1ns/1ps
module tb_glitc_dp_align_master;

  localparam int SETTLE = 4;
  localparam int NBITS  = 72;

  logic        user_clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic        abort_i;
  logic        busy_o, done_o, fail_o;
  logic        user_sel_o, user_wr_o;
  logic [3:0]  user_addr_o;
  logic [31:0] user_dat_o;
  logic [31:0] user_dat_i;
  logic        res_valid_o;
  logic [6:0]  res_sel_o;
  logic [4:0]  res_delay_o;
  logic [5:0]  res_width_o;
  logic [3:0]  res_slip_o;
  logic        res_ok_o;

  always #5 user_clk_i = ~user_clk_i;

  glitc_dp_align_master #(.SETTLE_CYCLES(SETTLE)) dut (
    .user_clk_i  (user_clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fail_o      (fail_o),
    .user_sel_o  (user_sel_o),
    .user_wr_o   (user_wr_o),
    .user_addr_o (user_addr_o),
    .user_dat_o  (user_dat_o),
    .user_dat_i  (user_dat_i),
    .res_valid_o (res_valid_o),
    .res_sel_o   (res_sel_o),
    .res_delay_o (res_delay_o),
    .res_width_o (res_width_o),
    .res_slip_o  (res_slip_o),
    .res_ok_o    (res_ok_o)
  );

  // Per-bit responder behaviour plus the record the DUT is expected to report for that bit.
  typedef struct {
    int lo, hi, lo2, hi2;
    int rot, gain;
    int exp_delay, exp_width, exp_slip, exp_ok;
    bit chk_delay;
  } vec_t;
  vec_t vec [NBITS];

  typedef struct {
    int sel, delay, width, slip, ok;
  } res_t;
  res_t res_q [$];

  int tests = 0;
  int fails = 0;

  // Responder state
  logic [31:0] trn_reg = '0;
  logic [31:0] dly_reg = '0;
  int m_bit = 0;
  int m_tap = 0;
  int m_slips = 0;

  // Monitor state
  int done_cnt = 0;
  int wr_cnt = 0;
  int bus_viol = 0;
  logic prev_sel = 1'b0;
  logic [3:0]  last_addr = '0;
  logic [31:0] last_dat = '0;
  int slip_wr [NBITS];

  function automatic logic [7:0] model_byte(input int b, input int tap, input int slips);
    logic [7:0] p;
    int n;
    if (b < 0 || b >= NBITS) return 8'h00;
    if (!((tap >= vec[b].lo && tap <= vec[b].hi) || (tap >= vec[b].lo2 && tap <= vec[b].hi2)))
      return 8'h00;
    p = 8'hA6;
    n = (vec[b].rot + vec[b].gain * slips) % 8;
    return (p << n) | (p >> (8 - n));
  endfunction

  assign user_dat_i = (user_addr_o == 4'h2) ? {trn_reg[31:8], model_byte(m_bit, m_tap, m_slips)} :
                      (user_addr_o == 4'h4) ? dly_reg : 32'h0;

  always @(posedge user_clk_i) begin
    if (user_sel_o && user_wr_o) begin
      if (user_addr_o == 4'h2) begin
        trn_reg <= user_dat_o;
        m_bit   <= int'(user_dat_o[22:20]) * 12 + int'(user_dat_o[19:16]);
        m_slips <= user_dat_o[30] ? m_slips + 1 : 0;
      end else if (user_addr_o == 4'h4) begin
        dly_reg <= user_dat_o;
        if (user_dat_o[31]) m_tap <= int'(user_dat_o[4:0]);
      end
    end
  end

  always @(negedge user_clk_i) begin
    res_t r;
    int idx;
    if (res_valid_o) begin
      r.sel = int'(res_sel_o); r.delay = int'(res_delay_o); r.width = int'(res_width_o);
      r.slip = int'(res_slip_o); r.ok = int'(res_ok_o);
      res_q.push_back(r);
    end
    if (done_o) done_cnt++;
    if (user_sel_o && prev_sel) bus_viol++;
    prev_sel = user_sel_o;
    if (user_sel_o && user_wr_o) begin
      wr_cnt++;
      last_addr = user_addr_o;
      last_dat  = user_dat_o;
      idx = int'(user_dat_o[22:20]) * 12 + int'(user_dat_o[19:16]);
      if (user_addr_o == 4'h2 && user_dat_o[30] && idx < NBITS) slip_wr[idx]++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge user_clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic pulse_abort();
    abort_i = 1'b1; tick(); abort_i = 1'b0;
  endtask

  function automatic int outs_nonzero();
    return int'(|{busy_o, done_o, fail_o, user_sel_o, user_wr_o, user_addr_o, user_dat_o,
                  res_valid_o, res_sel_o, res_delay_o, res_width_o, res_slip_o, res_ok_o});
  endfunction

  task automatic fill_default();
    for (int i = 0; i < NBITS; i++) begin
      vec[i] = '{lo: 10, hi: 19, lo2: -1, hi2: -1, rot: 2, gain: 1,
                 exp_delay: 15, exp_width: 10, exp_slip: 6, exp_ok: 1, chk_delay: 1'b1};
    end
  endtask

  task automatic wait_done(input string tag, input int d0, input int limit);
    int cyc;
    cyc = 0;
    while (done_cnt == d0 && cyc < limit) begin tick(); cyc++; end
    repeat (4) tick();
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_busy_low"}, int'(busy_o), 0);
  endtask

  task automatic check_results(input string tag, input int base, input int n);
    res_t r;
    check({tag, "_result_count"}, res_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < res_q.size()) begin
        r = res_q[base + i];
        check($sformatf("%s_b%0d_sel", tag, i), r.sel, (i / 12) * 16 + (i % 12));
        check($sformatf("%s_b%0d_width", tag, i), r.width, vec[i].exp_width);
        check($sformatf("%s_b%0d_slip", tag, i), r.slip, vec[i].exp_slip);
        check($sformatf("%s_b%0d_ok", tag, i), r.ok, vec[i].exp_ok);
        if (vec[i].chk_delay)
          check($sformatf("%s_b%0d_delay", tag, i), r.delay, vec[i].exp_delay);
      end
    end
  endtask

  initial begin
    int base, d0, cyc, wc, s43;
    bit found;
    for (int i = 0; i < NBITS; i++) slip_wr[i] = 0;
    rst_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    fill_default();
    repeat (3) tick();
    check("reset_outputs_zero", outs_nonzero(), 0);
    rst_n_i = 1'b1;
    repeat (2) tick();
    check("idle_outputs_zero", outs_nonzero(), 0);

    // Run 1: every bit has eye 10..19 rotated by 2; a start mid-run must be ignored.
    base = res_q.size(); d0 = done_cnt;
    pulse_start();
    check("run1_busy_after_start", int'(busy_o), 1);
    cyc = 0;
    while (res_q.size() - base < 10 && cyc < 20000) begin tick(); cyc++; end
    pulse_start();
    wait_done("run1", d0, 40000);
    check_results("run1", base, NBITS);
    check("run1_fail_o", int'(fail_o), 0);
    check("run1_last_wr_addr", int'(last_addr), 2);
    check("run1_last_wr_word", int'(last_dat), 32'h8000_0000);

    // Run 2: corner eyes on a few bits.
    vec[1].lo = 2;   vec[1].hi = 6;  vec[1].lo2 = 20; vec[1].hi2 = 24;
    vec[1].exp_delay = 4;  vec[1].exp_width = 5;
    vec[2].lo = 28;  vec[2].hi = 31;
    vec[2].exp_delay = 30; vec[2].exp_width = 4;
    vec[29].lo = 3;  vec[29].hi = 5;
    vec[29].exp_width = 3; vec[29].exp_slip = 0; vec[29].exp_ok = 0; vec[29].chk_delay = 1'b0;
    vec[43].gain = 0;
    vec[43].exp_slip = 8;  vec[43].exp_ok = 0;
    s43 = slip_wr[43];
    base = res_q.size(); d0 = done_cnt;
    pulse_start();
    wait_done("run2", d0, 40000);
    check_results("run2", base, NBITS);
    check("run2_fail_o", int'(fail_o), 1);
    check("run2_b43_slip_writes", slip_wr[43] - s43, 8);

    // Run 3: abort while settling after the first tap load of ch1/bit3.
    fill_default();
    base = res_q.size(); d0 = done_cnt;
    pulse_start();
    check("run3_fail_cleared", int'(fail_o), 0);
    found = 1'b0; cyc = 0;
    while (!found && cyc < 20000) begin
      tick(); cyc++;
      if (user_sel_o && user_wr_o && user_addr_o == 4'h4 && user_dat_o[22:16] == 7'h13) found = 1'b1;
    end
    check("run3_reached_ch1b3", int'(found), 1);
    tick();
    pulse_abort();
    wait_done("run3", d0, 200);
    repeat (50) tick();
    check("run3_result_count", res_q.size() - base, 15);
    check("run3_last_wr_addr", int'(last_addr), 2);
    check("run3_last_wr_disable", int'(last_dat[31]), 1);
    check("run3_fail_o", int'(fail_o), 1);

    // Run 4: reset during a SAMPLE read, then a fresh start from sel 0.
    base = res_q.size();
    pulse_start();
    found = 1'b0; cyc = 0;
    while (!found && cyc < 20000) begin
      tick(); cyc++;
      if (res_q.size() - base >= 2 && user_sel_o && !user_wr_o) found = 1'b1;
    end
    check("run4_reached_sample", int'(found), 1);
    rst_n_i = 1'b0;
    #1;
    check("run4_async_reset_zero", outs_nonzero(), 0);
    tick();
    rst_n_i = 1'b1;
    wc = wr_cnt;
    repeat (10) tick();
    check("run4_no_finish_write", wr_cnt - wc, 0);
    check("run4_idle_after_reset", int'(busy_o), 0);
    base = res_q.size(); d0 = done_cnt;
    pulse_start();
    cyc = 0;
    while (wr_cnt == wc && cyc < 100) begin tick(); cyc++; end
    check("run4_first_wr_addr", int'(last_addr), 2);
    check("run4_first_wr_word", int'(last_dat), 0);
    cyc = 0;
    while (res_q.size() - base < 3 && cyc < 5000) begin tick(); cyc++; end
    check_results("run4", base, 3);
    pulse_abort();
    wait_done("run4", d0, 200);

    check("bus_spacing_violations", bus_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/glitc_dp_align_master.md
Name: glitc_dp_align_master

Overview:
- Autonomous bus initiator that drives the 2xRITC datapath register interface (addresses 0x0–0x4) from the user-clock side.
- For every data bit it does three things:
  - sweeps the IDELAY and finds the widest window where the training pattern reads back stably;
  - centres the IDELAY in that window;
  - bitslips until the readback equals the expected pattern.
- It sits next to the host register master. The top level muxes the bus to this block while busy_o is high.
- It emits one result record per bit for logging or readback.

Parameters:
- TRAIN_PATTERN, 8'hA6, expected 8-bit training word at DPTRAINING[7:0].
- SETTLE_CYCLES, 64, user_clk cycles waited after any delay load or bitslip before a readback. Must be ≥ 2 SYSCLK periods plus 2 user_clk cycles.
- MIN_EYE, 4, minimum contiguous passing taps for a bit to be accepted.
- MAX_SLIP, 8, bitslip attempts allowed before the bit is declared failed.

Ports:
- user_clk_i, in, 1, sole clock.
- rst_n_i, in, 1, asynchronous active-low reset.
- start_i, in, 1, one-cycle pulse that starts a full alignment run.
- abort_i, in, 1, one-cycle pulse that abandons the run.
- busy_o, out, 1, high from start acceptance until done.
- done_o, out, 1, one-cycle pulse at the end of a run.
- fail_o, out, 1, sticky; set if any bit failed; cleared on start.
- user_sel_o, out, 1, bus select.
- user_wr_o, out, 1, bus write strobe.
- user_addr_o, out, 4, register address.
- user_dat_o, out, 32, write data.
- user_dat_i, in, 32, combinational readback of the addressed register.
- res_valid_o, out, 1, one-cycle pulse per bit result.
- res_sel_o, out, 7, bit select: [6:4] channel, [3:0] bit.
- res_delay_o, out, 5, chosen tap.
- res_width_o, out, 6, eye width in taps.
- res_slip_o, out, 4, number of bitslips applied.
- res_ok_o, out, 1, bit aligned successfully.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Bus cycle rules:
  - A write is exactly one cycle with sel=1, wr=1.
  - A read is one cycle with sel=1, wr=0, addr=2; user_dat_i[7:0] is captured at the end of that cycle.
  - At most one bus cycle per two clocks; sel=0 between cycles.
- Register fields used:
  - 0x2 DPTRAINING: [31] disable, [30] bitslip, [22:16] select.
  - 0x4 DPIDELAY: [31] load, [22:16] select, [4:0] tap.
- FSM states:
  - IDLE: on start_i, clear fail_o, set busy_o, set sel=0x00, go to SELECT.
  - SELECT: write 0x2 = {disable=0, bitslip=0, sel}. Go to LOAD with tap=0 and run trackers cleared (cur_start, cur_len, best_start, best_len).
  - LOAD: write 0x4 = {load=1, sel, tap}. Go to WAIT.
  - WAIT: count SETTLE_CYCLES, then go to SAMPLE.
  - SAMPLE: one read.
    - pass = the captured byte equals any of the 8 rotations of TRAIN_PATTERN.
    - On pass: cur_len++, and cur_start=tap if cur_len was 0.
    - On fail: cur_len=0.
    - Update best when cur_len > best_len; on a tie, keep the earlier window.
    - If tap==31 go to CENTER, else tap++ and go to LOAD.
  - CENTER: window search does not wrap.
    - If best_len < MIN_EYE: go to REPORT with ok=0.
    - Else tap = best_start + (best_len>>1), computed with 6-bit arithmetic and truncated to 5 bits. Write 0x4 with that tap, wait, go to CHECK.
  - CHECK: read.
    - If readback == TRAIN_PATTERN: go to REPORT with ok=1.
    - Else if slips == MAX_SLIP: go to REPORT with ok=0.
    - Else write 0x2 with bitslip=1, slips++, wait, then CHECK again.
  - REPORT:
    - Pulse res_valid_o with all res_* fields valid in the same cycle.
    - fail_o |= !ok.
    - Advance sel: bit increments 0..11; bit 11 wraps to 0 with channel+1. Bits 12–15 are never visited.
    - After channel 5 bit 11, go to FINISH; else go to SELECT.
  - FINISH: write 0x2 = {disable=1}. Pulse done_o, drop busy_o, return to IDLE.
- Ordering rules:
  - start_i while busy is ignored.
  - abort_i has priority over every state. It completes any bus cycle being driven this clock, then goes to FINISH with no further res_valid. fail_o is set.
  - Reset mid-run: the bus idles immediately and there is no FINISH write.
- Run length: 72 bits total. Worst case is about 72×(32+9)×(SETTLE_CYCLES+4) cycles.

Decomposition:
- Shared package:
  - register addresses 0x0–0x4;
  - DPTRAINING field positions 31, 30, 22:16, 7:0;
  - DPIDELAY field positions 31, 22:16, 4:0;
  - NUM_CH=6, NUM_BIT=12.
- Sub-module glitc_eye_tracker: consumes (clear, pass_valid, pass, tap) and produces best_start and best_len (6-bit). It holds the run-length logic on its own so it can be unit-tested.

Test Plan:
- Bench responder model: register file, with a model mapping tap → readback. All bits pass on taps 10–19 with the pattern rotated by 2. Start → 72 results, each with delay=15, width=10, ok=1. Each needs slip count such that the model's rotation is cancelled; the model rotates by 1 per bitslip, so slip=6. fail_o=0, done_o pulses once.
- Bit ch2/bit5 passes on taps 3–5 only → that record has width=3, ok=0. fail_o=1; all other bits ok.
- Two windows, 2–6 and 20–24 → width=5, delay=4 (earlier window on tie). A window of 28–31 followed by a fail at tap 0 → no wrap, width=4, delay=30.
- Model never matches after slips → slip=8, ok=0. Exactly 8 bitslip writes observed.
- abort_i during WAIT of ch1/bit3 → no further res_valid. Last bus write is 0x2 with [31]=1. done_o pulses, busy_o=0.
- rst_n_i low mid-SAMPLE → all outputs 0 asynchronously. After release, start_i runs a fresh full sweep beginning at sel=0x00.
